// File: rtl/framer_pkg.sv
// Shared types and constants for the sample framer: frame geometry, state encoding
// and the per-index frame byte selector.
package framer_pkg;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
  localparam int         FRAME_LEN      = 5;
  localparam logic [2:0] LAST_IDX       = 3'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    WAIT_DONE
  } framer_state_t;

  // Byte idx of a frame; the checksum covers header, seq and both payload bytes.
  function automatic logic [7:0] frame_byte(
    input logic [2:0]  idx,
    input logic [7:0]  header,
    input logic [7:0]  seq,
    input logic [15:0] sample
  );
    logic [7:0] result;
    case (idx)
      3'd0:    result = header;
      3'd1:    result = seq;
      3'd2:    result = sample[15:8];
      3'd3:    result = sample[7:0];
      default: result = header ^ seq ^ sample[15:8] ^ sample[7:0];
    endcase
    return result;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock FIFO with first-word-fall-through read data. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sample_framer.sv
// Turns averaged sensor samples into 5-byte UART frames: header, sequence number,
// sample high/low bytes and an XOR checksum, buffered through a small FIFO.
module sample_framer
  import framer_pkg::*;
#(
  parameter int         WIDTH  = 16,
  parameter int         DEPTH  = 4,
  parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       sample_in,
  input  logic                   sample_valid,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic                   frame_active,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_level
);

  framer_state_t    state_q;
  framer_state_t    state_d;
  logic [WIDTH-1:0] frame_q;
  logic [2:0]       idx_q;
  logic [7:0]       seq_q;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (sample_valid),
    .push_data (sample_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!fifo_empty) state_d = SEND;
      SEND:      state_d = WAIT_ACK;
      WAIT_ACK:  if (tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = (idx_q == LAST_IDX) ? IDLE : SEND;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_start     = (state_q == SEND);
    frame_active = (state_q != IDLE);
    fifo_pop     = (state_q == IDLE) && !fifo_empty;
  end

  // tx_data is loaded on entry to SEND so it is stable for the whole start cycle
  // and then holds the last sent byte while the UART shifts it out.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q  <= '0;
      idx_q    <= '0;
      seq_q    <= '0;
      tx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      if (sample_valid && fifo_full && !fifo_pop) begin
        overflow <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            frame_q <= fifo_data;
            idx_q   <= '0;
            tx_data <= HEADER;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (idx_q == LAST_IDX) begin
              seq_q <= seq_q + 8'd1;
            end else begin
              idx_q   <= idx_q + 3'd1;
              tx_data <= frame_byte(idx_q + 3'd1, HEADER, seq_q, frame_q);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
